// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - shared-port register file sequencer for operand reads and writebacks
// Optional REGCTL_ZERO_SKIP_EN: x0 source reads are skipped and their operand forced to 0.
module reg_access_ctrl #(
  parameter int AW = 3,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [AW-1:0] regAddr,
  input  logic [DW-1:0] regData,
  output logic [DW-1:0] x8,
  output logic          writeReg
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, DONE, WR} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] rs1_q, rs2_q, wb_addr_q;
  logic [DW-1:0] wb_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        if (wb_valid) begin
          wb_addr_q <= wb_addr;
          wb_data_q <= wb_data;
        end else if (req_valid) begin
          rs1_q <= rs1;
          rs2_q <= rs2;
`ifdef REGCTL_ZERO_SKIP_EN
          // skipped reads leave their operand at zero
          op_a  <= '0;
          op_b  <= '0;
`endif
        end
      end
      if (state == RD_A) op_a <= regData;
      if (state == RD_B) op_b <= regData;
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    wb_ready  = 1'b0;
    op_valid  = 1'b0;
    regAddr   = '0;
    x8        = '0;
    writeReg  = 1'b0;
    case (state)
      IDLE: begin
        // writeback wins over a simultaneous operand request
        wb_ready  = 1'b1;
        req_ready = !wb_valid;
        if (wb_valid) begin
          state_nx = WR;
        end else if (req_valid) begin
`ifdef REGCTL_ZERO_SKIP_EN
          if (rs1 == '0 && rs2 == '0) state_nx = DONE;
          else if (rs1 == '0)         state_nx = RD_B;
          else                        state_nx = RD_A;
`else
          state_nx = RD_A;
`endif
        end
      end
      RD_A: begin
        regAddr = rs1_q;
`ifdef REGCTL_ZERO_SKIP_EN
        state_nx = (rs2_q == '0) ? DONE : RD_B;
`else
        state_nx = RD_B;
`endif
      end
      RD_B: begin
        regAddr  = rs2_q;
        state_nx = DONE;
      end
      DONE: begin
        op_valid = 1'b1;
        if (op_ready) state_nx = IDLE;
      end
      WR: begin
        regAddr  = wb_addr_q;
        x8       = wb_data_q;
        writeReg = (wb_addr_q != '0);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb/tb_reg_access_ctrl.sv - directed and randomized bench for reg_access_ctrl with a register file model
module tb_reg_access_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [2:0] rs1, rs2;
  logic       op_valid, op_ready;
  logic [5:0] op_a, op_b;
  logic       wb_valid, wb_ready;
  logic [2:0] wb_addr;
  logic [5:0] wb_data;
  logic [2:0] regAddr;
  logic [5:0] regData;
  logic [5:0] x8;
  logic       writeReg;

  int checks = 0;
  int failures = 0;

  logic [5:0] rf   [8];
  logic [5:0] arch [8];

  reg_access_ctrl #(.AW(3), .DW(6)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .rs1(rs1), .rs2(rs2),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .regAddr(regAddr), .regData(regData), .x8(x8), .writeReg(writeReg)
  );

  always #5 clk = ~clk;

  // register file environment: combinational read, write on negedge
  assign regData = rf[regAddr];
  always @(negedge clk) if (writeReg) rf[regAddr] <= x8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [2:0] a, input logic [2:0] b);
`ifdef REGCTL_ZERO_SKIP_EN
    return 1 + ((a != 0) ? 1 : 0) + ((b != 0) ? 1 : 0);
`else
    return 3;
`endif
  endfunction

  task automatic do_wb(input logic [2:0] a, input logic [5:0] d);
    wb_addr = a; wb_data = d; wb_valid = 1'b1;
    #1;
    check("wb_ready_idle", wb_ready, 1);
    check("req_ready_wb_prio", req_ready, 0);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    check("wr_regaddr", regAddr, a);
    check("wr_x8", x8, d);
    check("wr_writereg", writeReg, (a != 0));
    check("wr_wb_ready", wb_ready, 0);
    if (a != 0) arch[a] = d;
    @(posedge clk); #1;
    check("wr_back_idle", wb_ready, 1);
    check("idle_writereg", writeReg, 0);
  endtask

  task automatic do_req(input logic [2:0] a, input logic [2:0] b, input int hold, input logic early);
    int n;
    int lat;
    logic hs;
    logic [5:0] ea, eb;
    ea = arch[a]; eb = arch[b];
    rs1 = a; rs2 = b; req_valid = 1'b1; op_ready = early;
    n = 0;
    do begin
      #1; hs = req_ready;
      @(posedge clk); n++;
    end while (!hs && n < 20);
    check("req_handshake", hs, 1);
    #1;
    req_valid = 1'b0; rs1 = $urandom; rs2 = $urandom;
    lat = 1;
    while (!op_valid && lat < 10) begin
      check("busy_req_ready", req_ready, 0);
      check("busy_wb_ready", wb_ready, 0);
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, exp_latency(a, b));
    check("op_a", op_a, ea);
    check("op_b", op_b, eb);
    op_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_op_valid", op_valid, 1);
      check("hold_op_a", op_a, ea);
      check("hold_op_b", op_b, eb);
      check("hold_req_ready", req_ready, 0);
    end
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    check("consumed_op_valid", op_valid, 0);
    check("consumed_req_ready", req_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin rf[i] = '0; arch[i] = '0; end
    reset = 1'b1; req_valid = 1'b0; op_ready = 1'b0; wb_valid = 1'b0;
    rs1 = '0; rs2 = '0; wb_addr = '0; wb_data = '0;
    #2;
    check("rst_op_valid", op_valid, 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_regaddr", regAddr, 0);
    check("rst_x8", x8, 0);
    check("rst_writereg", writeReg, 0);
    #10 reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_req_ready", req_ready, 1);

    do_wb(3'd3, 6'h2A);
    do_req(3'd3, 3'd0, 0, 1'b0);

    // wb and req together: write goes first, request waits one IDLE cycle
    rs1 = 3'd5; rs2 = 3'd5; req_valid = 1'b1;
    do_wb(3'd5, 6'h11);
    do_req(3'd5, 3'd5, 4, 1'b0);

    do_wb(3'd0, 6'h3F);
    check("x0_rf_untouched", rf[0], 0);
    do_req(3'd0, 3'd0, 1, 1'b1);

    // reset while in RD_B drops the request immediately
    do_wb(3'd2, 6'h15);
    do_wb(3'd4, 6'h07);
    rs1 = 3'd2; rs2 = 3'd4; req_valid = 1'b1;
    #1; @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rdb_regaddr", regAddr, 4);
    check("rdb_op_a_loaded", op_a, 6'h15);
    reset = 1'b1;
    #1;
    check("midrst_op_valid", op_valid, 0);
    check("midrst_writereg", writeReg, 0);
    check("midrst_regaddr", regAddr, 0);
    check("midrst_op_a", op_a, 0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("after_rst_req_ready", req_ready, 1);
    @(posedge clk); #1;
    check("after_rst_idle", op_valid, 0);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1)
        do_wb(3'($urandom_range(0, 7)), 6'($urandom));
      else
        do_req(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 8; i++) check("final_rf", rf[i], arch[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
